// File: rtl/line_readout_sequencer_if.sv
// Signal bundle between the line readout sequencer, its line buffer and the
// downstream pixel consumer.
interface line_readout_sequencer_if #(
  parameter int unsigned LW     = 9,
  parameter int unsigned CW     = 10,
  parameter int unsigned DATA_W = 10
);
  logic              ENABLE;
  logic              FRAME_START;
  logic [LW-1:0]     FIRST_LINE;
  logic [LW-1:0]     LINE_STEP;
  logic              LINE_READY;
  logic [DATA_W-1:0] BUF_DATA;
  logic [LW-1:0]     INTERESTING_LINE;
  logic [CW-1:0]     READ_ADDRESS;
  logic              RESET_READY_FLAG;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              OUT_LAST;
  logic [LW-1:0]     OUT_LINE;
  logic              FRAME_DONE;
  logic              OVERRUN;

  modport master (
    input  ENABLE, FRAME_START, FIRST_LINE, LINE_STEP, LINE_READY, BUF_DATA, OUT_READY,
    output INTERESTING_LINE, READ_ADDRESS, RESET_READY_FLAG,
           OUT_DATA, OUT_VALID, OUT_LAST, OUT_LINE, FRAME_DONE, OVERRUN
  );

  modport slave (
    output ENABLE, FRAME_START, FIRST_LINE, LINE_STEP, LINE_READY, BUF_DATA, OUT_READY,
    input  INTERESTING_LINE, READ_ADDRESS, RESET_READY_FLAG,
           OUT_DATA, OUT_VALID, OUT_LAST, OUT_LINE, FRAME_DONE, OVERRUN
  );
endinterface

// File: rtl/line_readout_sequencer.sv
// Sequences the single-line camera buffer: programs a target line, waits for it,
// streams its pixels through a 2-entry skid FIFO, then releases the buffer.
module line_readout_sequencer #(
  parameter int unsigned LINES   = 480,
  parameter int unsigned COLUMNS = 752,
  parameter int unsigned DATA_W  = 10
) (
  input logic                      CLK,
  input logic                      RESET_N,
  line_readout_sequencer_if.master bus
);
  localparam int unsigned LW  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned CW  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int unsigned LWX = LW + 1;
  localparam logic [LWX-1:0] LINES_X  = LWX'(LINES);
  localparam logic [CW-1:0]  LAST_COL = CW'(COLUMNS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LINE, S_READ, S_DRAIN, S_RELEASE
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } pix_t;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic [LW-1:0]   step_q, step_d;
  logic            skip_q, skip_d;
  logic [CW-1:0]   addr_cnt_q, addr_cnt_d;
  logic [CW-1:0]   rd_addr_q, rd_addr_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;
  pix_t            head_q, head_d;
  pix_t            tail_q, tail_d;
  logic            head_v_q, head_v_d;
  logic            tail_v_q, tail_v_d;
  logic [LW-1:0]   out_line_q, out_line_d;
  logic            rrf_q, rrf_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;

  logic            pop_c;
  logic [1:0]      occ_c;
  logic            credit_c;
  logic [LWX-1:0]  next_line_c;

  // Occupancy counts the slot freed by this cycle's pop so a full-rate stream needs no bubble.
  assign pop_c       = head_v_q & bus.OUT_READY;
  assign occ_c       = 2'(head_v_q) + 2'(tail_v_q) + 2'(inflight_q) - 2'(pop_c);
  assign credit_c    = (occ_c < 2'd2);
  assign next_line_c = LWX'(line_q) + LWX'(step_q);

  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    step_d          = step_q;
    skip_d          = skip_q;
    addr_cnt_d      = addr_cnt_q;
    rd_addr_d       = rd_addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    head_d          = head_q;
    head_v_d        = head_v_q;
    tail_d          = tail_q;
    tail_v_d        = tail_v_q;
    out_line_d      = out_line_q;
    rrf_d           = 1'b0;
    done_d          = 1'b0;
    overrun_d       = overrun_q;

    // Skid FIFO: dequeue first, then land the returning read in the first free slot.
    if (pop_c) begin
      head_d   = tail_v_q ? tail_q : '0;
      head_v_d = tail_v_q;
      tail_v_d = 1'b0;
    end
    if (inflight_q) begin
      if (!head_v_d) begin
        head_d   = '{last: inflight_last_q, data: bus.BUF_DATA};
        head_v_d = 1'b1;
      end else begin
        tail_d   = '{last: inflight_last_q, data: bus.BUF_DATA};
        tail_v_d = 1'b1;
      end
    end

    if (state_q != S_IDLE && bus.FRAME_START) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!bus.ENABLE) begin
          overrun_d = 1'b0;
        end else if (bus.FRAME_START) begin
          step_d = (bus.LINE_STEP == '0) ? LW'(1) : bus.LINE_STEP;
          if (LWX'(bus.FIRST_LINE) >= LINES_X) begin
            done_d = 1'b1;
          end else begin
            line_d  = bus.FIRST_LINE;
            skip_d  = 1'b0;
            state_d = S_WAIT_LINE;
          end
        end
      end
      S_WAIT_LINE: begin
        // The buffer's flag still reads high for one cycle after a release.
        if (bus.FRAME_START) begin
          state_d = S_IDLE;
        end else if (skip_q) begin
          skip_d = 1'b0;
        end else if (bus.LINE_READY) begin
          addr_cnt_d = '0;
          out_line_d = line_q;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        if (credit_c) begin
          rd_addr_d       = addr_cnt_q;
          inflight_d      = 1'b1;
          inflight_last_d = (addr_cnt_q == LAST_COL);
          addr_cnt_d      = addr_cnt_q + CW'(1);
          if (addr_cnt_q == LAST_COL) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!head_v_q && !tail_v_q && !inflight_q) begin
          rrf_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (next_line_c >= LINES_X || !bus.ENABLE) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          line_d  = next_line_c[LW-1:0];
          skip_d  = 1'b1;
          state_d = S_WAIT_LINE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= S_IDLE;
      line_q          <= '0;
      step_q          <= '0;
      skip_q          <= 1'b0;
      addr_cnt_q      <= '0;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_q          <= '0;
      head_v_q        <= 1'b0;
      tail_q          <= '0;
      tail_v_q        <= 1'b0;
      out_line_q      <= '0;
      rrf_q           <= 1'b0;
      done_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      line_q          <= line_d;
      step_q          <= step_d;
      skip_q          <= skip_d;
      addr_cnt_q      <= addr_cnt_d;
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      head_q          <= head_d;
      head_v_q        <= head_v_d;
      tail_q          <= tail_d;
      tail_v_q        <= tail_v_d;
      out_line_q      <= out_line_d;
      rrf_q           <= rrf_d;
      done_q          <= done_d;
      overrun_q       <= overrun_d;
    end
  end

  assign bus.INTERESTING_LINE = line_q;
  assign bus.READ_ADDRESS     = rd_addr_q;
  assign bus.RESET_READY_FLAG = rrf_q;
  assign bus.OUT_DATA         = head_q.data;
  assign bus.OUT_VALID        = head_v_q;
  assign bus.OUT_LAST         = head_q.last;
  assign bus.OUT_LINE         = out_line_q;
  assign bus.FRAME_DONE       = done_q;
  assign bus.OVERRUN          = overrun_q;
endmodule

// File: tb/tb_line_readout_sequencer.sv
// Bench for line_readout_sequencer: a behavioural line buffer and consumer,
// with a pixel scoreboard filled when each frame is started.
module tb_line_readout_sequencer;
  localparam int LINES   = 3;
  localparam int COLUMNS = 2;
  localparam int DATA_W  = 10;
  localparam int LW      = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CW      = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int FILL    = 4;

  typedef struct {
    int data;
    int last;
    int line;
  } exp_t;

  logic clk;
  logic rst_n;

  line_readout_sequencer_if #(.LW(LW), .CW(CW), .DATA_W(DATA_W)) bus ();

  line_readout_sequencer #(.LINES(LINES), .COLUMNS(COLUMNS), .DATA_W(DATA_W)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, ready_mode = 0;
  int   filled_line = 99, rel_cnt = 0, fill_cnt = 0;
  int   done_cnt = 0, rrf_cnt = 0, xfer_cnt = 0;
  int   last_xfer_cyc = 0, last_was_last = 0;
  int   n, r0, d0, x0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Line buffer and consumer model, driven just after each rising edge.
  initial begin
    bus.LINE_READY = 1'b0;
    bus.BUF_DATA   = '0;
    bus.OUT_READY  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       bus.OUT_READY = 1'b1;
        1:       bus.OUT_READY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.OUT_READY = 1'b0;
      endcase
      if (bus.RESET_READY_FLAG) begin
        rel_cnt = 2;
      end else if (rel_cnt != 0) begin
        rel_cnt--;
        if (rel_cnt == 0) begin
          bus.LINE_READY = 1'b0;
          fill_cnt = 0;
        end
      end else if (bus.LINE_READY && filled_line != int'(bus.INTERESTING_LINE)) begin
        bus.LINE_READY = 1'b0;
        fill_cnt = 0;
      end else if (!bus.LINE_READY) begin
        fill_cnt++;
        if (fill_cnt == FILL) begin
          bus.LINE_READY = 1'b1;
          filled_line = int'(bus.INTERESTING_LINE);
        end
      end
      bus.BUF_DATA = DATA_W'(10 * (filled_line + 1) + int'(bus.READ_ADDRESS) + 1);
    end
  end

  // Output monitor: every valid cycle must show the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.OUT_VALID) begin
        check_eq("sb_has_entry", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          e = sb[0];
          check_eq("out_data", 32'(bus.OUT_DATA), 32'(e.data));
          check_eq("out_last", 32'(bus.OUT_LAST), 32'(e.last));
          check_eq("out_line", 32'(bus.OUT_LINE), 32'(e.line));
          if (bus.OUT_READY) begin
            void'(sb.pop_front());
            xfer_cnt++;
            if (ready_mode == 0 && e.last != 0)
              check_eq("back_to_back", 32'(cyc - last_xfer_cyc), 32'(1));
            last_xfer_cyc = cyc;
            last_was_last = e.last;
          end
        end
      end
      if (bus.RESET_READY_FLAG) begin
        rrf_cnt++;
        check_eq("release_after_last", 32'(last_was_last), 32'(1));
        last_was_last = 0;
      end
      if (bus.FRAME_DONE) done_cnt++;
    end
  end

  task automatic push_frame(input int first, input int step, input int max_lines, output int nl);
    int l;
    int s;
    s  = (step == 0) ? 1 : step;
    l  = first;
    nl = 0;
    while (l < LINES && nl < max_lines) begin
      for (int c = 0; c < COLUMNS; c++)
        sb.push_back('{data: 10 * (l + 1) + c + 1, last: int'(c == COLUMNS - 1), line: l});
      nl++;
      l += s;
    end
  endtask

  task automatic start_frame(input int first, input int step);
    @(posedge clk);
    #1;
    bus.FRAME_START = 1'b1;
    bus.FIRST_LINE  = LW'(first);
    bus.LINE_STEP   = LW'(step);
    @(posedge clk);
    #1;
    bus.FRAME_START = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!bus.OUT_VALID && i < 500) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_valid_seen"}, 32'(bus.OUT_VALID), 32'(1));
  endtask

  task automatic wait_done(input string tag);
    int start;
    int i;
    start = done_cnt;
    i = 0;
    while (done_cnt == start && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_done"}, 32'(done_cnt), 32'(start + 1));
    repeat (4) @(negedge clk);
    check_eq({tag, "_done_once"}, 32'(done_cnt), 32'(start + 1));
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic run_frame(input string tag, input int first, input int step);
    int nl;
    int rs;
    push_frame(first, step, 99, nl);
    rs = rrf_cnt;
    start_frame(first, step);
    wait_done(tag);
    check_eq({tag, "_releases"}, 32'(rrf_cnt - rs), 32'(nl));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_interesting_line"}, 32'(bus.INTERESTING_LINE), 32'(0));
    check_eq({tag, "_read_address"},     32'(bus.READ_ADDRESS),     32'(0));
    check_eq({tag, "_reset_ready_flag"}, 32'(bus.RESET_READY_FLAG), 32'(0));
    check_eq({tag, "_out_data"},         32'(bus.OUT_DATA),         32'(0));
    check_eq({tag, "_out_valid"},        32'(bus.OUT_VALID),        32'(0));
    check_eq({tag, "_out_last"},         32'(bus.OUT_LAST),         32'(0));
    check_eq({tag, "_out_line"},         32'(bus.OUT_LINE),         32'(0));
    check_eq({tag, "_frame_done"},       32'(bus.FRAME_DONE),       32'(0));
    check_eq({tag, "_overrun"},          32'(bus.OVERRUN),          32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.ENABLE      = 1'b1;
    bus.FRAME_START = 1'b0;
    bus.FIRST_LINE  = '0;
    bus.LINE_STEP   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (8) @(posedge clk);

    ready_mode = 0;
    run_frame("basic", 1, 1);
    ready_mode = 1;
    run_frame("stall", 1, 1);
    ready_mode = 0;
    run_frame("step0", 1, 0);

    // First line beyond the frame: immediate done, no reads.
    d0 = done_cnt;
    x0 = xfer_cnt;
    start_frame(3, 1);
    check_eq("oob_done_next_cycle", 32'(bus.FRAME_DONE), 32'(1));
    repeat (6) @(negedge clk);
    check_eq("oob_done_count", 32'(done_cnt - d0), 32'(1));
    check_eq("oob_no_xfer", 32'(xfer_cnt - x0), 32'(0));
    check_eq("oob_read_address", 32'(bus.READ_ADDRESS), 32'(COLUMNS - 1));

    // Frame start mid-line: flagged, frame completes unchanged.
    push_frame(1, 1, 99, n);
    r0 = rrf_cnt;
    start_frame(1, 1);
    wait_valid("ovr_line");
    start_frame(0, 1);
    wait_done("ovr_line");
    check_eq("ovr_line_releases", 32'(rrf_cnt - r0), 32'(n));
    check_eq("ovr_line_overrun", 32'(bus.OVERRUN), 32'(1));

    // Asynchronous reset while the FIFO is stalled full.
    ready_mode = 2;
    push_frame(1, 1, 99, n);
    start_frame(1, 1);
    wait_valid("rst_drain");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    ready_mode    = 0;
    last_was_last = 0;
    run_frame("after_reset_step2", 0, 2);

    // Frame start while waiting for a line: back to IDLE, no reads.
    d0 = done_cnt;
    r0 = rrf_cnt;
    x0 = xfer_cnt;
    start_frame(0, 1);
    bus.FRAME_START = 1'b1;
    @(posedge clk);
    #1;
    bus.FRAME_START = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("ovr_wait_overrun", 32'(bus.OVERRUN), 32'(1));
    check_eq("ovr_wait_no_done", 32'(done_cnt - d0), 32'(0));
    check_eq("ovr_wait_no_release", 32'(rrf_cnt - r0), 32'(0));
    check_eq("ovr_wait_no_xfer", 32'(xfer_cnt - x0), 32'(0));
    @(posedge clk);
    #1;
    bus.ENABLE = 1'b0;
    @(posedge clk);
    #1;
    check_eq("overrun_cleared", 32'(bus.OVERRUN), 32'(0));
    bus.ENABLE = 1'b1;

    // Enable dropped mid-line: the line completes, then the frame ends.
    push_frame(0, 1, 1, n);
    r0 = rrf_cnt;
    start_frame(0, 1);
    wait_valid("en_drop");
    @(posedge clk);
    #1;
    bus.ENABLE = 1'b0;
    wait_done("en_drop");
    bus.ENABLE = 1'b1;
    check_eq("en_drop_releases", 32'(rrf_cnt - r0), 32'(1));

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
